// File: rtl/program_loader.sv
// Boot loader: assembles little-endian instruction words from a byte stream and
// writes them through the core's debug imem port, holding the core in reset meanwhile.
module program_loader #(
  parameter int               XLEN               = 64,
  parameter int               INSTRUCTION_LENGTH = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR          = '0,
  parameter int               MAX_WORDS          = 1024,
  parameter int               TIMEOUT_CYCLES     = 100000,
  parameter int               RELEASE_CYCLES     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_req,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  // state   | meaning
  // LEN     | collecting the 4-byte word count N
  // DATA    | collecting the 4 bytes of the next instruction
  // WRITE   | one-cycle imem write strobe
  // RELEASE | holding core reset for RELEASE_CYCLES after the last write
  // RUN     | core running; waits for load_req
  localparam logic [2:0] S_LEN     = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  localparam int          WIDX  = $clog2(MAX_WORDS + 1);
  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int          RW    = $clog2(RELEASE_CYCLES + 1);
  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [WIDX-1:0] word_idx;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   rel_cnt;
  logic [31:0]     n_words;
  logic [31:0]     word_buf;
  logic [31:0]     asm_next;
  logic            hs;
  logic            timed;

  assign rx_ready  = !rst && (state == S_LEN || state == S_DATA);
  assign hs        = rx_valid && rx_ready;
  assign timed     = (state == S_LEN && byte_cnt != 2'd0) || state == S_DATA;
  assign dbg_wr_en = (state == S_WRITE);
  assign core_rst  = (state != S_RUN);
  assign busy      = (state != S_RUN);
  assign done      = (state == S_RUN);

  // Count and instruction bytes share one little-endian byte-insert path.
  always_comb begin
    asm_next = (state == S_DATA) ? word_buf : n_words;
    asm_next[{byte_cnt, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LEN;
      byte_cnt  <= '0;
      word_idx  <= '0;
      timer     <= '0;
      rel_cnt   <= '0;
      n_words   <= '0;
      word_buf  <= '0;
      dbg_addr  <= BASE_ADDR;
      dbg_instr <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_LEN, S_DATA: begin
          if (hs) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_LEN) n_words <= asm_next;
            else                word_buf <= asm_next;
            if (byte_cnt == 2'd3) begin
              if (state == S_LEN) begin
                if (asm_next == 32'd0) begin
                  state   <= S_RELEASE;
                  rel_cnt <= RW'(RELEASE_CYCLES - 1);
                end else if (asm_next > MAX_N) begin
                  err <= 1'b1;
                end else begin
                  state <= S_DATA;
                end
              end else begin
                state     <= S_WRITE;
                dbg_instr <= INSTRUCTION_LENGTH'(asm_next);
                dbg_addr  <= BASE_ADDR + XLEN'({word_idx, 2'b00});
              end
            end
          end else if (timed) begin
            // Abandon the frame; words already written stay in imem.
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
              err      <= 1'b1;
              state    <= S_LEN;
              byte_cnt <= '0;
              word_idx <= '0;
              timer    <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            timer <= '0;
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + WIDX'(1);
          if (32'(word_idx) + 32'd1 == n_words) begin
            state   <= S_RELEASE;
            rel_cnt <= RW'(RELEASE_CYCLES - 1);
          end else begin
            state <= S_DATA;
          end
        end
        S_RELEASE: begin
          if (rel_cnt == '0) state <= S_RUN;
          else               rel_cnt <= rel_cnt - RW'(1);
        end
        S_RUN: begin
          if (load_req) begin
            state    <= S_LEN;
            err      <= 1'b0;
            byte_cnt <= '0;
            word_idx <= '0;
            timer    <= '0;
          end
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule
